// File: rtl/morse_decoder.sv
// Morse key decoder: times presses/releases on a tick timebase and emits ITU character codes.
// Optional MORSE_WORD_GAP_EN adds a WORD state that emits a space (code 62) after a long pause.
module morse_decoder #(
   parameter int TICK_DIV   = 100000,
   parameter int DASH_TICKS = 300,
   parameter int GAP_TICKS  = 600,
   parameter int WORD_TICKS = 1400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       key_in,
   output logic [5:0] char_code,
   output logic       char_valid,
   output logic       err,
   output logic [2:0] sym_count,
   output logic [4:0] sym_bits,
   output logic [2:0] o_dbg_state
);
   localparam int CNT_MAX = (WORD_TICKS > GAP_TICKS) ?
                            ((WORD_TICKS > DASH_TICKS) ? WORD_TICKS : DASH_TICKS) :
                            ((GAP_TICKS > DASH_TICKS) ? GAP_TICKS : DASH_TICKS);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PRESS, S_GAP, S_EMIT, S_WORD} state_t;

   state_t             r_state;
   logic               r_key_meta;
   logic               r_key_s;
   logic [PRE_W-1:0]   r_presc;
   logic [CNT_W-1:0]   r_press_cnt;
   logic [CNT_W-1:0]   r_gap_cnt;
   logic               r_ovf;
   logic [5:0]         r_char_code;
   logic               r_char_valid;
   logic               r_err;
   logic [2:0]         r_sym_count;
   logic [4:0]         r_sym_bits;

   logic               w_tick;
   logic               w_dash;
   logic [5:0]         w_code;
   logic [5:0]         w_emit_code;

   // Pattern bit i is symbol i (first symbol in bit 0), 1 = dash; unused upper bits are always 0.
   function automatic logic [5:0] lookup(input logic [2:0] cnt, input logic [4:0] bits);
      logic [5:0] code;
      code = 6'd63;
      case ({cnt, bits})
         {3'd2, 5'b00010}: code = 6'd10;
         {3'd4, 5'b00001}: code = 6'd11;
         {3'd4, 5'b00101}: code = 6'd12;
         {3'd3, 5'b00001}: code = 6'd13;
         {3'd1, 5'b00000}: code = 6'd14;
         {3'd4, 5'b00100}: code = 6'd15;
         {3'd3, 5'b00011}: code = 6'd16;
         {3'd4, 5'b00000}: code = 6'd17;
         {3'd2, 5'b00000}: code = 6'd18;
         {3'd4, 5'b01110}: code = 6'd19;
         {3'd3, 5'b00101}: code = 6'd20;
         {3'd4, 5'b00010}: code = 6'd21;
         {3'd2, 5'b00011}: code = 6'd22;
         {3'd2, 5'b00001}: code = 6'd23;
         {3'd3, 5'b00111}: code = 6'd24;
         {3'd4, 5'b00110}: code = 6'd25;
         {3'd4, 5'b01011}: code = 6'd26;
         {3'd3, 5'b00010}: code = 6'd27;
         {3'd3, 5'b00000}: code = 6'd28;
         {3'd1, 5'b00001}: code = 6'd29;
         {3'd3, 5'b00100}: code = 6'd30;
         {3'd4, 5'b01000}: code = 6'd31;
         {3'd3, 5'b00110}: code = 6'd32;
         {3'd4, 5'b01001}: code = 6'd33;
         {3'd4, 5'b01101}: code = 6'd34;
         {3'd4, 5'b00011}: code = 6'd35;
         {3'd5, 5'b11111}: code = 6'd0;
         {3'd5, 5'b11110}: code = 6'd1;
         {3'd5, 5'b11100}: code = 6'd2;
         {3'd5, 5'b11000}: code = 6'd3;
         {3'd5, 5'b10000}: code = 6'd4;
         {3'd5, 5'b00000}: code = 6'd5;
         {3'd5, 5'b00001}: code = 6'd6;
         {3'd5, 5'b00011}: code = 6'd7;
         {3'd5, 5'b00111}: code = 6'd8;
         {3'd5, 5'b01111}: code = 6'd9;
         default:          code = 6'd63;
      endcase
      return code;
   endfunction

   assign w_tick      = (r_presc == PRE_W'(TICK_DIV - 1));
   assign w_dash      = (r_press_cnt >= CNT_W'(DASH_TICKS));
   assign w_code      = lookup(r_sym_count, r_sym_bits);
   assign w_emit_code = r_ovf ? 6'd63 : w_code;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_key_meta   <= 1'b0;
         r_key_s      <= 1'b0;
         r_presc      <= '0;
         r_press_cnt  <= '0;
         r_gap_cnt    <= '0;
         r_ovf        <= 1'b0;
         r_char_code  <= 6'd0;
         r_char_valid <= 1'b0;
         r_err        <= 1'b0;
         r_sym_count  <= 3'd0;
         r_sym_bits   <= 5'd0;
      end else begin
         r_key_meta   <= key_in;
         r_key_s      <= r_key_meta;
         r_presc      <= w_tick ? '0 : r_presc + 1'b1;
         r_char_valid <= 1'b0;
         r_err        <= 1'b0;
         if (!en) begin
            r_state     <= S_IDLE;
            r_press_cnt <= '0;
            r_gap_cnt   <= '0;
            r_ovf       <= 1'b0;
            r_sym_count <= 3'd0;
            r_sym_bits  <= 5'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (r_key_s) begin
                     r_state     <= S_PRESS;
                     r_press_cnt <= '0;
                  end
               end
               S_PRESS: begin
                  if (!r_key_s) begin
                     if (r_sym_count < 3'd5) begin
                        r_sym_bits  <= r_sym_bits | (5'(w_dash) << r_sym_count);
                        r_sym_count <= r_sym_count + 3'd1;
                     end else begin
                        r_ovf <= 1'b1;
                     end
                     r_gap_cnt <= '0;
                     r_state   <= S_GAP;
                  end else if (w_tick && (r_press_cnt < CNT_W'(DASH_TICKS))) begin
                     r_press_cnt <= r_press_cnt + 1'b1;
                  end
               end
               S_GAP: begin
                  if (r_key_s) begin
                     r_state     <= S_PRESS;
                     r_press_cnt <= '0;
                  end else if (w_tick) begin
                     r_gap_cnt <= r_gap_cnt + 1'b1;
                     // Strobe is launched here so it is visible in the EMIT cycle itself.
                     if (r_gap_cnt == CNT_W'(GAP_TICKS - 1)) begin
                        r_state      <= S_EMIT;
                        r_char_valid <= 1'b1;
                        r_char_code  <= w_emit_code;
                        r_err        <= (w_emit_code == 6'd63);
                     end
                  end
               end
               S_EMIT: begin
                  r_sym_count <= 3'd0;
                  r_sym_bits  <= 5'd0;
                  r_ovf       <= 1'b0;
                  if (w_tick) r_gap_cnt <= r_gap_cnt + 1'b1;
`ifdef MORSE_WORD_GAP_EN
                  r_state <= S_WORD;
`else
                  r_state <= S_IDLE;
`endif
               end
`ifdef MORSE_WORD_GAP_EN
               S_WORD: begin
                  if (r_key_s) begin
                     r_state     <= S_PRESS;
                     r_press_cnt <= '0;
                  end else if (w_tick) begin
                     r_gap_cnt <= r_gap_cnt + 1'b1;
                     if (r_gap_cnt >= CNT_W'(WORD_TICKS - 1)) begin
                        r_state      <= S_IDLE;
                        r_char_valid <= 1'b1;
                        r_char_code  <= 6'd62;
                     end
                  end
               end
`endif
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign char_code   = r_char_code;
   assign char_valid  = r_char_valid;
   assign err         = r_err;
   assign sym_count   = r_sym_count;
   assign sym_bits    = r_sym_bits;
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder with a fast timebase; honours MORSE_WORD_GAP_EN when defined.
module tb_morse_decoder;
   localparam int TICK = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic       key_in;
   logic [5:0] char_code;
   logic       char_valid;
   logic       err;
   logic [2:0] sym_count;
   logic [4:0] sym_bits;
   logic [2:0] dbg_state;

   int n_tests;
   int n_fail;
   logic [6:0] exp_q[$];

   morse_decoder #(
      .TICK_DIV(TICK), .DASH_TICKS(3), .GAP_TICKS(6), .WORD_TICKS(14)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .key_in(key_in),
      .char_code(char_code), .char_valid(char_valid), .err(err),
      .sym_count(sym_count), .sym_bits(sym_bits), .o_dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * TICK) @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      logic [6:0] e;
      if (char_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {26'd0, char_code}, 32'd99);
         end else begin
            e = exp_q.pop_front();
            check("char_code", {26'd0, char_code}, {26'd0, e[5:0]});
            check("err", {31'd0, err}, {31'd0, e[6]});
         end
      end else if (err) begin
         check("err_without_valid", {31'd0, err}, 32'd0);
      end
   end

   task automatic send_symbols(input logic [7:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         key_in = 1'b1;
         wait_ticks(bits[i] ? $urandom_range(6, 4) : $urandom_range(2, 1));
         key_in = 1'b0;
         if (i < n - 1) wait_ticks($urandom_range(3, 1));
      end
   endtask

   task automatic push_exp(input logic [5:0] code, input logic e);
      exp_q.push_back({e, code});
`ifdef MORSE_WORD_GAP_EN
      exp_q.push_back({1'b0, 6'd62});
`endif
   endtask

   task automatic end_letter(input logic [5:0] code);
      wait_ticks(20);
`ifdef MORSE_WORD_GAP_EN
      check("code_hold", {26'd0, char_code}, 32'd62);
`else
      check("code_hold", {26'd0, char_code}, {26'd0, code});
`endif
      check("sym_count_clear", {29'd0, sym_count}, 32'd0);
   endtask

   task automatic send_letter(input logic [7:0] bits, input int n, input logic [5:0] code,
                              input logic e);
      push_exp(code, e);
      send_symbols(bits, n);
      end_letter(code);
   endtask

   function automatic logic [4:0] digit_bits(input int d);
      logic [4:0] b;
      for (int i = 0; i < 5; i++) b[i] = (d <= 5) ? (i >= d) : (i < d - 5);
      return b;
   endfunction

   initial begin
      int d;
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      en      = 1'b1;
      key_in  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_code", {26'd0, char_code}, 32'd0);
      check("rst_valid", {31'd0, char_valid}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_count", {29'd0, sym_count}, 32'd0);
      check("rst_bits", {27'd0, sym_bits}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, 32'd0);

      // Reset in the middle of a press discards everything.
      key_in = 1'b1;
      wait_ticks(3);
      check("press_state", {29'd0, dbg_state}, 32'd1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      key_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_ticks(10);
      check("midrst_count", {29'd0, sym_count}, 32'd0);
      check("midrst_bits", {27'd0, sym_bits}, 32'd0);
      check("midrst_code", {26'd0, char_code}, 32'd0);
      check("midrst_state", {29'd0, dbg_state}, 32'd0);

      // 'A' with fixed timing and a live pattern check before the gap expires.
      push_exp(6'd10, 1'b0);
      key_in = 1'b1; wait_ticks(1);
      key_in = 1'b0; wait_ticks(2);
      key_in = 1'b1; wait_ticks(5);
      key_in = 1'b0; wait_ticks(2);
      check("A_bits", {27'd0, sym_bits}, 32'd2);
      check("A_count", {29'd0, sym_count}, 32'd2);
      end_letter(6'd10);

      // Five dashes, then five dots.
      push_exp(6'd0, 1'b0);
      send_symbols(8'h1f, 5);
      wait_ticks(2);
      check("dash5_bits", {27'd0, sym_bits}, 32'd31);
      check("dash5_count", {29'd0, sym_count}, 32'd5);
      end_letter(6'd0);
      send_letter(8'h00, 5, 6'd5, 1'b0);

      // Overflow and an unlisted 4-symbol pattern.
      send_letter(8'h00, 6, 6'd63, 1'b1);
      send_letter(8'h0c, 4, 6'd63, 1'b1);

      // Enable dropped mid-letter; presses while disabled are ignored.
      send_symbols(8'h00, 2);
      wait_ticks(1);
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("en_count", {29'd0, sym_count}, 32'd0);
      check("en_bits", {27'd0, sym_bits}, 32'd0);
      check("en_state", {29'd0, dbg_state}, 32'd0);
      key_in = 1'b1; wait_ticks(5);
      key_in = 1'b0; wait_ticks(2);
      en = 1'b1;
      wait_ticks(20);
      check("en_idle_count", {29'd0, sym_count}, 32'd0);
      send_letter(8'h00, 1, 6'd14, 1'b0);

      // Assorted letters and random digits.
      send_letter(8'h01, 1, 6'd29, 1'b0);
      send_letter(8'h05, 3, 6'd20, 1'b0);
      send_letter(8'h0b, 4, 6'd26, 1'b0);
      send_letter(8'h03, 4, 6'd35, 1'b0);
      send_letter(8'h00, 3, 6'd28, 1'b0);
      for (int k = 0; k < 6; k++) begin
         d = $urandom_range(9, 0);
         send_letter({3'b000, digit_bits(d)}, 5, 6'(d), 1'b0);
      end

      wait_ticks(5);
      check("exp_q_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
